// File: rtl/hist_pkg.sv
// hist_pkg: shared types and constants for histogram_axi_reader (bin count default, FSM states, AXI responses, CDF saturation)
package hist_pkg;
  localparam int HIST_NUM_BINS = 256;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [31:0] CDF_SAT = 32'hFFFF_FFFF;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? CDF_SAT : s[31:0];
  endfunction
endpackage

// File: rtl/histogram_axi_reader.sv
// histogram_axi_reader: sweeps NUM_BINS 32-bit bins over AXI read (one outstanding), emits index/count/CDF per bin.
// Ports: clk, rst (async active-low), start/busy/done/err control, AXI AR/R master channels, bin_idx/bin_count/bin_cdf/bin_valid stream.
// Build option: define HIST_READER_CDF_EN to build the saturating CDF accumulator; otherwise bin_cdf is tied to 0.
module histogram_axi_reader
  import hist_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int NUM_BINS = HIST_NUM_BINS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [7:0]  bin_idx,
  output logic [31:0] bin_count,
  output logic [31:0] bin_cdf,
  output logic        bin_valid
);
  localparam logic [7:0] LAST = 8'(NUM_BINS - 1);
  state_t state;
  logic [7:0] idx;
  function automatic logic [31:0] addr_of(input logic [7:0] i);
    return BASE_ADDR + 32'(ADDR_BITS'({i, 2'b00}));
  endfunction
`ifdef HIST_READER_CDF_EN
  logic [31:0] acc;
  logic [31:0] cdf_next;
  always_comb cdf_next = sat_add(acc, m_axi_rdata);
`else
  assign bin_cdf = '0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
      bin_idx <= '0;
      bin_count <= '0;
      bin_valid <= 1'b0;
`ifdef HIST_READER_CDF_EN
      acc <= '0;
      bin_cdf <= '0;
`endif
    end else begin
      bin_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ADDR;
          idx <= '0;
          err <= 1'b0;
          busy <= 1'b1;
          m_axi_arvalid <= 1'b1;
          m_axi_araddr <= addr_of(8'd0);
`ifdef HIST_READER_CDF_EN
          acc <= '0;
`endif
        end
        ADDR: if (m_axi_arready) begin
          state <= DATA;
          m_axi_arvalid <= 1'b0;
          m_axi_rready <= 1'b1;
        end
        DATA: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          bin_valid <= 1'b1;
          bin_idx <= idx;
          bin_count <= m_axi_rdata;
          if (m_axi_rresp != OKAY) err <= 1'b1;
`ifdef HIST_READER_CDF_EN
          acc <= cdf_next;
          bin_cdf <= cdf_next;
`endif
          if (idx == LAST) state <= FIN;
          else begin
            state <= ADDR;
            idx <= idx + 8'd1;
            m_axi_arvalid <= 1'b1;
            m_axi_araddr <= addr_of(idx + 8'd1);
          end
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_histogram_axi_reader.sv
// tb_histogram_axi_reader: table-driven sweeps against a cycle-level AXI slave model with directed expected values.
module tb_histogram_axi_reader;
  import hist_pkg::*;
`ifdef HIST_READER_CDF_EN
  localparam bit CDF = 1'b1;
`else
  localparam bit CDF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, err, m_axi_arvalid, m_axi_rready, bin_valid;
  logic m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [31:0] m_axi_araddr, bin_count, bin_cdf;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0] m_axi_rresp = '0;
  logic [7:0] bin_idx;
  int compared = 0, mismatched = 0;
  bit prev_err = 1'b0;
  always #5 clk = ~clk;
  histogram_axi_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .bin_idx(bin_idx), .bin_count(bin_count),
    .bin_cdf(bin_cdf), .bin_valid(bin_valid)
  );
  typedef struct {
    int ar_dly; int r_dly; int mode; int err_bin; bit noise;
    logic [31:0] last_cdf; bit exp_err; int mid_start; int rst_bin;
  } cfg_t;
  cfg_t tbl[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] val(input int mode, input int i);
    return mode == 0 ? 32'(i) : mode == 1 ? 32'h8000_0000 : 32'(i * 3 + 1);
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_bin_idx"}, bin_idx, 0);
    chk({tag, "_bin_count"}, bin_count, 0);
    chk({tag, "_bin_cdf"}, bin_cdf, 0);
    chk({tag, "_bin_valid"}, bin_valid, 0);
  endtask
  task automatic run(input cfg_t c);
    int cyc = 0, n = 0, last_bin = -100, ar_cnt = 0, r_cnt = 0, exp_ar = 0, out_idx = 0;
    bit outst = 0, ar_hs = 0, r_hs = 0, fin = 0;
    logic [32:0] acc = '0;
    logic [31:0] seen_cdf = '0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_err_held", err, prev_err);
    start = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = (cyc == c.mid_start);
      if (ar_hs) begin
        outst = 1; out_idx = exp_ar; exp_ar++; ar_cnt = 0; r_cnt = 0;
        chk("ar_gap", m_axi_arvalid, 0);
      end
      if (r_hs) outst = 0;
      ar_hs = 0; r_hs = 0;
      if (cyc == 1) chk("start_clears_err", err, 0);
      chk("valid_done_excl", {31'd0, bin_valid & done}, 0);
      if (bin_valid) begin
        acc = acc + {1'b0, val(c.mode, n)};
        if (acc[32]) acc = {1'b0, CDF_SAT};
        chk("bin_idx", bin_idx, n);
        chk("bin_count", bin_count, val(c.mode, n));
        chk("bin_cdf", bin_cdf, CDF ? acc[31:0] : 32'd0);
        chk("bin_err", err, (c.err_bin >= 0 && n >= c.err_bin) ? 1 : 0);
        if (n == 0 && c.ar_dly == 0 && c.r_dly == 0) chk("first_latency", cyc, 3);
        seen_cdf = bin_cdf;
        n++;
        last_bin = cyc;
      end
      if (done) begin
        chk("done_bins", n, 256);
        chk("done_timing", cyc, last_bin + 1);
        chk("done_err", err, c.exp_err);
        chk("done_busy", busy, 0);
        chk("last_cdf", seen_cdf, CDF ? c.last_cdf : 32'd0);
        prev_err = c.exp_err;
        fin = 1;
      end else chk("busy_during", busy, 1);
      if (bin_valid && int'(bin_idx) == c.rst_bin) begin
        rst = 1'b0; start = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (3) begin
          @(negedge clk);
          chk("midrst_no_done", done, 0);
          chk("midrst_busy", busy, 0);
        end
        rst = 1'b1;
        prev_err = 1'b0;
        return;
      end
      if (m_axi_arvalid) begin
        chk("one_outstanding", outst, 0);
        chk("araddr", m_axi_araddr, 32'(exp_ar * 4));
        m_axi_arready = (ar_cnt == c.ar_dly);
        ar_hs = m_axi_arready;
        if (!ar_hs) ar_cnt++;
      end else m_axi_arready = c.noise;
      if (m_axi_rready) begin
        chk("rready_in_data", outst, 1);
        m_axi_rvalid = (r_cnt == c.r_dly);
        m_axi_rdata = val(c.mode, out_idx);
        m_axi_rresp = (out_idx == c.err_bin) ? SLVERR : OKAY;
        r_hs = m_axi_rvalid;
        if (!r_hs) r_cnt++;
      end else begin
        m_axi_rvalid = c.noise;
        m_axi_rdata = 32'hDEAD_BEEF;
        m_axi_rresp = SLVERR;
      end
      if (cyc > 4000) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
    end
    start = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, -1, 0, 32'd32640, 0, -1, -1};
    tbl[1] = '{3, 2, 2, -1, 1, 32'd98176, 0, -1, -1};
    tbl[2] = '{0, 0, 0, 7, 0, 32'd32640, 1, -1, -1};
    tbl[3] = '{1, 0, 0, -1, 1, 32'd32640, 0, -1, -1};
    tbl[4] = '{0, 0, 1, -1, 0, 32'hFFFF_FFFF, 0, -1, -1};
    tbl[5] = '{0, 1, 0, -1, 0, 32'd0, 0, 20, 100};
    tbl[6] = '{0, 0, 0, -1, 0, 32'd32640, 0, -1, -1};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 7; i++) run(tbl[i]);
    repeat (3) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
